writeback_arbiter: RTL

Writeback stage of the dummy32 core, directly upstream of the register file. It merges single-cycle results from the main pipeline with results from the long-latency unit (mul/div, loads on miss) and drives the register-file write port from a registered output. It buffers long-latency results in a small FIFO and keeps a per-register busy scoreboard so decode can stall on pending destinations.

---
 rtl/dummy32_pkg.sv | 15 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/writeback_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dummy32_pkg.sv
// Shared dummy32 core types: architectural widths and the writeback entry.
// No logic, no latency.
// No flow control; types only.
package dummy32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of writeback entries for long-latency results.
// Head is visible the cycle after a push; pushes when full and pops when empty are dropped.
// The caller gates push with !full and pop with !empty.
module wb_fifo
    import dummy32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The extra MSB on each pointer separates the full case from the empty case.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipe and long-latency results onto the register-file write port; keeps a busy scoreboard.
// Latency: pipe result one edge to writeEn; lu result at least two edges to the register file.
// Backpressure: luReady = !full; stallPipe after STARVE_LIMIT cycles of the FIFO head losing.
module writeback_arbiter
    import dummy32_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipeValid,
    input  logic [REG_AW-1:0] pipeRd,
    input  logic [XLEN-1:0]   pipeData,
    output logic              stallPipe,
    input  logic              luValid,
    output logic              luReady,
    input  logic [REG_AW-1:0] luRd,
    input  logic [XLEN-1:0]   luData,
    input  logic              issueValid,
    input  logic [REG_AW-1:0] issueRd,
    input  logic [REG_AW-1:0] qAddr1,
    input  logic [REG_AW-1:0] qAddr2,
    output logic              qBusy1,
    output logic              qBusy2,
    output logic              writeEn,
    output logic [REG_AW-1:0] writeAddr,
    output logic [XLEN-1:0]   writeData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_entry_t lu_entry;
    wb_entry_t head;
    wb_entry_t wb_q;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    logic      pipe_win;
    logic      from_lu;
    logic [3:0] starve_cnt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    assign lu_entry = '{rd: luRd, data: luData};
    assign luReady  = !rst && !fifo_full;
    assign push     = luValid && luReady;

    assign stallPipe = (starve_cnt == LIMIT);
    assign pipe_win  = pipeValid && !stallPipe;
    assign pop       = !pipe_win && !fifo_empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (lu_entry),
        .pop  (pop),
        .head (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (pipe_win) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // rd 0 winners are consumed but never raise writeEn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q    <= '0;
            writeEn <= 1'b0;
            from_lu <= 1'b0;
        end else if (pipe_win) begin
            wb_q    <= '{rd: pipeRd, data: pipeData};
            writeEn <= (pipeRd != '0);
            from_lu <= 1'b0;
        end else if (pop) begin
            wb_q    <= head;
            writeEn <= (head.rd != '0);
            from_lu <= 1'b1;
        end else begin
            writeEn <= 1'b0;
            from_lu <= 1'b0;
        end
    end

    assign writeAddr = wb_q.rd;
    assign writeData = wb_q.data;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (writeEn && from_lu) begin
            busy_nxt[writeAddr] = 1'b0;
        end
        if (issueValid && (issueRd != '0)) begin
            busy_nxt[issueRd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign qBusy1 = (qAddr1 != '0) && busy[qAddr1];
    assign qBusy2 = (qAddr2 != '0) && busy[qAddr2];

endmodule
